// File: rtl/io_port_bank.sv
// -----------------------------------------------------------------------------
// io_port_bank
//
// Memory-mapped I/O bank between a monocycle CPU datapath and external
// producers/consumers. Provides N_PORTS input channels (valid/ready) and
// N_PORTS output channels (valid/ack) of WIDTH bits each, plus a status
// register. CPU reads are combinational so a load completes in one cycle.
//
// Address map:
//   0 .. N_PORTS-1 : data channel i (read = input holding reg, write = output)
//   N_PORTS        : status {0.., out_valid[N-1:0], full[N-1:0]} (read only)
//   N_PORTS+1      : irq mask (only with IO_PORT_BANK_IRQ_EN), else reads 0
//   others         : read 0, writes ignored
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   addr       CPU register select
//   rd_en      CPU read strobe; consumes the addressed FULL input channel
//   wr_en      CPU write strobe
//   wdata      CPU write data
//   rdata      CPU read data (combinational from addr)
//   in_data    input channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   producer has data on channel i
//   in_ready   channel i holding register empty
//   out_data   registered output data, same packing as in_data
//   out_valid  channel i holds data not yet acknowledged
//   out_ack    consumer accepts channel i
//   irq        (IO_PORT_BANK_IRQ_EN only) registered OR of full & mask
//
// Optional feature macro: IO_PORT_BANK_IRQ_EN
// -----------------------------------------------------------------------------
module io_port_bank #(
    parameter int WIDTH   = 8,
    parameter int N_PORTS = 4,
    parameter int ADDR_W  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       rd_en,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    input  logic [N_PORTS*WIDTH-1:0]   in_data,
    input  logic [N_PORTS-1:0]         in_valid,
    output logic [N_PORTS-1:0]         in_ready,
    output logic [N_PORTS*WIDTH-1:0]   out_data,
    output logic [N_PORTS-1:0]         out_valid,
    input  logic [N_PORTS-1:0]         out_ack
`ifdef IO_PORT_BANK_IRQ_EN
    ,
    output logic                       irq
`endif
);

    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(N_PORTS);
`ifdef IO_PORT_BANK_IRQ_EN
    localparam logic [ADDR_W-1:0] MASK_ADDR   = ADDR_W'(N_PORTS + 1);
`endif

    logic [N_PORTS-1:0]       full_vec;
    logic [N_PORTS*WIDTH-1:0] hold_flat;
    logic [WIDTH-1:0]         status_w;

    // -------------------------------------------------------------------------
    // Per-channel input and output state
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_ch
            logic             sel;
            logic             full_q, full_d;
            logic [WIDTH-1:0] hold_q, hold_d;
            logic             oval_q, oval_d;
            logic [WIDTH-1:0] odat_q, odat_d;

            assign sel = (addr == ADDR_W'(gi));

            always_comb begin
                full_d = full_q;
                hold_d = hold_q;
                // Capture only while EMPTY; in_ready is ~full so a capture and
                // a consume can never coincide on one channel.
                if (!full_q && in_valid[gi]) begin
                    full_d = 1'b1;
                    hold_d = in_data[gi*WIDTH +: WIDTH];
                end else if (full_q && rd_en && sel) begin
                    full_d = 1'b0;  // captured data is kept for later reads
                end

                oval_d = oval_q;
                odat_d = odat_q;
                // A write beats a simultaneous ack so fresh data is never lost.
                if (wr_en && sel) begin
                    odat_d = wdata;
                    oval_d = 1'b1;
                end else if (out_ack[gi]) begin
                    oval_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    full_q <= 1'b0;
                    hold_q <= '0;
                    oval_q <= 1'b0;
                    odat_q <= '0;
                end else begin
                    full_q <= full_d;
                    hold_q <= hold_d;
                    oval_q <= oval_d;
                    odat_q <= odat_d;
                end
            end

            assign full_vec[gi]                  = full_q;
            assign hold_flat[gi*WIDTH +: WIDTH]  = hold_q;
            assign out_valid[gi]                 = oval_q;
            assign out_data[gi*WIDTH +: WIDTH]   = odat_q;
        end
    endgenerate

    assign in_ready = ~full_vec;

    always_comb begin
        status_w                      = '0;
        status_w[N_PORTS-1:0]         = full_vec;
        status_w[2*N_PORTS-1:N_PORTS] = out_valid;
    end

`ifdef IO_PORT_BANK_IRQ_EN
    // -------------------------------------------------------------------------
    // Interrupt mask and registered interrupt
    // -------------------------------------------------------------------------
    logic [N_PORTS-1:0] mask_q, mask_d;
    logic               irq_q, irq_d;

    always_comb begin
        mask_d = mask_q;
        if (wr_en && (addr == MASK_ADDR)) begin
            mask_d = wdata[N_PORTS-1:0];
        end
        // Sampled from the registered flags, so irq lags a flag change by one
        // cycle.
        irq_d = |(full_vec & mask_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    // -------------------------------------------------------------------------
    // Combinational CPU read mux
    // -------------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rdata = hold_flat[i*WIDTH +: WIDTH];
            end
        end
        if (addr == STATUS_ADDR) begin
            rdata = status_w;
        end
`ifdef IO_PORT_BANK_IRQ_EN
        if (addr == MASK_ADDR) begin
            rdata = WIDTH'(mask_q);
        end
`endif
    end

endmodule

// File: tb/tb_io_port_bank.sv
// -----------------------------------------------------------------------------
// tb_io_port_bank
//
// Directed testbench for io_port_bank (WIDTH=8, N_PORTS=4, ADDR_W=3).
// Stimulus is driven #1 after each rising edge; checks are taken at that point
// or after a further #1 for combinational reads.
// -----------------------------------------------------------------------------
module tb_io_port_bank;

    logic        clk;
    logic        reset;
    logic [2:0]  addr;
    logic        rd_en;
    logic        wr_en;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ack;
`ifdef IO_PORT_BANK_IRQ_EN
    logic        irq;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    io_port_bank #(.WIDTH(8), .N_PORTS(4), .ADDR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack)
`ifdef IO_PORT_BANK_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(tag, {24'h0, rdata}, {24'h0, exp});
    endtask

    initial begin
        // Reset asserted with all producers valid
        reset    = 1'b0;
        addr     = 3'd0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        wdata    = 8'h00;
        in_data  = 32'h44332211;
        in_valid = 4'b1111;
        out_ack  = 4'b0000;
        tick();
        chk("rst_in_ready", in_ready, 4'b1111);
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_out_data", out_data, 32'h0);
        rd_chk("rst_status", 3'd4, 8'h00);
        rd_chk("rst_hold0", 3'd0, 8'h00);

        // Release; first edge captures all four channels
        reset = 1'b1;
        tick();
        in_valid = 4'b0000;
        chk("cap_in_ready", in_ready, 4'b0000);
        rd_chk("cap_status", 3'd4, 8'h0F);
        rd_chk("cap_rd0", 3'd0, 8'h11);
        rd_chk("cap_rd1", 3'd1, 8'h22);
        rd_chk("cap_rd2", 3'd2, 8'h33);
        rd_chk("cap_rd3", 3'd3, 8'h44);

        // Consume channels one at a time
        addr = 3'd0; rd_en = 1'b1; tick();
        chk("consume0", in_ready, 4'b0001);
        addr = 3'd1; tick();
        chk("consume1", in_ready, 4'b0011);
        addr = 3'd2; tick();
        chk("consume2", in_ready, 4'b0111);
        addr = 3'd3; tick();
        chk("consume3", in_ready, 4'b1111);
        rd_en = 1'b0;
        rd_chk("retain_rd2", 3'd2, 8'h33);

        // Input handshake on channel 1
        in_data = 32'h00000800; in_valid = 4'b0010; tick();
        in_data = 32'h00000900;
        chk("hs_in_ready", in_ready, 4'b1101);
        rd_chk("hs_status", 3'd4, 8'h02);
        rd_chk("hs_rd1", 3'd1, 8'h08);
        tick();
        chk("hs_full_ignore", in_ready, 4'b1101);
        rd_chk("hs_rd1_held", 3'd1, 8'h08);
        // rd_en on an empty channel changes nothing
        addr = 3'd0; rd_en = 1'b1; tick();
        chk("rd_empty_noop", in_ready, 4'b1101);
        addr = 3'd1; tick();
        rd_en = 1'b0; in_valid = 4'b0000;
        chk("hs_consume1", in_ready, 4'b1111);
        rd_chk("hs_rd1_after", 3'd1, 8'h08);

        // Output handshake on channel 3
        addr = 3'd3; wdata = 8'd128; wr_en = 1'b1; tick();
        wr_en = 1'b0;
        chk("out_data3", out_data, 32'h80000000);
        chk("out_valid3", out_valid, 4'b1000);
        rd_chk("out_status", 3'd4, 8'h80);
        out_ack = 4'b1000; tick();
        out_ack = 4'b0000;
        chk("ack_valid3", out_valid, 4'b0000);
        chk("ack_data3", out_data, 32'h80000000);
        out_ack = 4'b0001; tick();
        out_ack = 4'b0000;
        chk("ack_idle", out_valid, 4'b0000);

        // Write/ack collision on channel 0
        addr = 3'd0; wdata = 8'd5; wr_en = 1'b1; tick();
        chk("col_pre_data", out_data, 32'h80000005);
        wdata = 8'd7; out_ack = 4'b0001; tick();
        wr_en = 1'b0; out_ack = 4'b0000;
        chk("col_data", out_data, 32'h80000007);
        chk("col_valid", out_valid, 4'b0001);

        // Unmapped and status writes are ignored
        addr = 3'd7; wdata = 8'hFF; wr_en = 1'b1; tick();
        addr = 3'd4; tick();
        wr_en = 1'b0;
        chk("unmap_data", out_data, 32'h80000007);
        chk("unmap_valid", out_valid, 4'b0001);
        rd_chk("unmap_status", 3'd4, 8'h10);
        rd_chk("unmap_rd7", 3'd7, 8'h00);
`ifndef IO_PORT_BANK_IRQ_EN
        rd_chk("unmap_rd5", 3'd5, 8'h00);
`endif

        // Asynchronous reset mid-handshake
        in_data = 32'h00AA0000; in_valid = 4'b0100; tick();
        in_valid = 4'b0000;
        chk("pre_rst_ready", in_ready, 4'b1011);
        #2 reset = 1'b0;
        #1;
        chk("async_in_ready", in_ready, 4'b1111);
        chk("async_out_valid", out_valid, 4'b0000);
        chk("async_out_data", out_data, 32'h0);
        rd_chk("async_rd2", 3'd2, 8'h00);
        // Writes during reset are ignored
        addr = 3'd1; wdata = 8'h55; wr_en = 1'b1; tick();
        wr_en = 1'b0;
        chk("rst_wr_ignored", out_valid, 4'b0000);
        reset = 1'b1;

`ifdef IO_PORT_BANK_IRQ_EN
        chk("irq_reset", {31'h0, irq}, 32'h0);
        addr = 3'd5; wdata = 8'h04; wr_en = 1'b1; tick();
        wr_en = 1'b0;
        rd_chk("mask_rd", 3'd5, 8'h04);
        in_data = 32'h00330000; in_valid = 4'b0100; tick();
        in_valid = 4'b0000;
        chk("irq_lag", {31'h0, irq}, 32'h0);
        tick();
        chk("irq_set", {31'h0, irq}, 32'h1);
        addr = 3'd2; rd_en = 1'b1; tick();
        rd_en = 1'b0;
        chk("irq_hold", {31'h0, irq}, 32'h1);
        tick();
        chk("irq_clear", {31'h0, irq}, 32'h0);
        in_data = 32'h00000001; in_valid = 4'b0001; tick();
        in_valid = 4'b0000;
        tick();
        chk("irq_masked", {31'h0, irq}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net: the directed sequence is short, so this should never fire.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
